systolic_feeder: RTL
====================

# systolic_feeder

Operand staging and skew generator placed directly upstream of the 4x4 `array` MAC mesh. It holds one 4x4 operand matrix A (activations) and one 4x4 operand matrix B (weights), loaded one row per write. On `start` it clears the array accumulators for one cycle. It then drives `a_in`/`b_in` with the diagonal-skewed schedule for C = A x B, holds `we` for the feed window, and pulses `done` once every product term has reached every PE.

## Interface
- DATA_WIDTH, 8, operand byte width (matches the array).
- N, 4, matrix dimension; the design is fixed at 4 and is not required to scale.

- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write one operand row this cycle; honoured only in IDLE.
- load_sel  in  1  0 = write matrix A, 1 = write matrix B.
- load_row  in  2  row index k.
- load_data  in  32  byte j = element [k][j] (bits 8j+7:8j).
- start  in  1  begin a computation; honoured only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the results in the array are final.
- array_rst_n  out  1  accumulator clear to the array; active-low.
- we  out  1  MAC enable to the array.
- a_in  out  32  byte y = activation for array row y.
- b_in  out  32  byte x = weight for array column x.

## Operation
- Storage: A[4][4] and B[4][4] bytes. All bytes clear to 0 on rst. A write to a row replaces all four bytes of that row. If `load_en` and `start` are high together in IDLE, the write commits and the computation starts.
- The states are IDLE, CLEAR, FEED, DRAIN and DONE. Transitions:
  - IDLE -> CLEAR on `start`.
  - CLEAR -> FEED after 1 cycle.
  - FEED lasts 10 cycles, step t = 0..9, using a 4-bit counter.
  - DRAIN lasts 1 cycle.
  - DONE lasts 1 cycle, then returns to IDLE.
- CLEAR: `array_rst_n` = 0, `we` = 0, and operands are 0.
- FEED step t: `we` = 1.
  - a_in byte y = A[y][t-y] if 0 <= t-y <= 3, else 0.
  - b_in byte x = B[t-x][x] if 0 <= t-x <= 3, else 0.
- PE contract: a PE consumes its inputs on the edge that ends the cycle in which they are presented, and forwards them with one register of delay. PE[y][x] therefore performs the MAC for step t at the end of cycle t+x+y. Its last MAC is at step 9 (PE[3][3], k = 3). After that, c[y][x] = sum over k of A[y][k]*B[k][x].
- DRAIN: `we` = 0 and operands are 0. This gives one settling cycle for the final accumulator register.
- DONE: `done` = 1 for exactly one cycle. The array outputs are valid from this cycle until the next `start`.
- `start` and `load_en` are ignored outside IDLE. Matrix contents are held across computations, so a repeated `start` recomputes the same product.
- The block treats operand bytes as opaque. It performs no arithmetic beyond indexing and does not depend on signedness.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values: `busy` = 0, `done` = 0, `array_rst_n` = 0, `we` = 0, `a_in` = 0, `b_in` = 0, state = IDLE, counter = 0.
- After rst deasserts, `array_rst_n` = 1 from the next cycle. It returns to 0 only in CLEAR.
- Cycle numbering: `start` is sampled high at edge E0.
  - Cycle 1 (after E0): CLEAR; `busy` = 1, `array_rst_n` = 0.
  - Cycles 2..11: FEED steps 0..9, `we` = 1.
  - Cycle 12: DRAIN.
  - Cycle 13: `done` = 1.
  - Cycle 14: IDLE, `busy` = 0; a new `start` may be sampled at the end of cycle 14.
- Start-to-done latency is 13 cycles. Minimum start-to-start period is 14 cycles.
- rst mid-operation (any state): the next cycle shows reset values on all outputs, the state is IDLE, and both matrices are zeroed. No `done` is produced for the aborted run.
- Counter: it saturates at the end of FEED (9 -> FEED exit) and never wraps into a second feed.

## Test plan
- A = identity, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; `start` -> `done` exactly 13 cycles after the `start` edge, array c[y][x] = B[y][x].
- Schedule check with A[y][k] = 16y+k+1 and B[k][x] = 16k+x+0x81:
  - FEED step 3: a_in = {A[3][0],A[2][1],A[1][2],A[0][3]} = 0x31_22_13_04 (byte 3..0); b_in byte x = B[3-x][x].
  - FEED step 9: a_in = 0 and b_in = 0.
  - `we` is high for exactly 10 consecutive cycles.
- A all 3, B all 5 -> every c = 60. Then `start` again with no reload -> every c = 60 again, proving the accumulators are cleared and not 120.
- `start` and `load_en` (A row 0 = 0xFFFFFFFF) pulsed during FEED -> no restart, `done` on its original cycle, A row 0 unchanged.
- rst asserted at FEED step 4 -> next cycle `we` = 0, `busy` = 0, `array_rst_n` = 0, no `done`. A subsequent `start` without loads gives all c = 0.
- `load_en` together with `start` in IDLE (A row 2 = 0x01010101, B = all 1, other A rows 0) -> the load commits, row 2 results = 4, other rows = 0.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: operand load/start controls and skewed feed outputs to the MAC array
interface systolic_feeder_if;
    logic        load_en;
    logic        load_sel;
    logic [1:0]  load_row;
    logic [31:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        array_rst_n;
    logic        we;
    logic [31:0] a_in;
    logic [31:0] b_in;
    modport master (
        output load_en, load_sel, load_row, load_data, start,
        input  busy, done, array_rst_n, we, a_in, b_in
    );
    modport slave (
        input  load_en, load_sel, load_row, load_data, start,
        output busy, done, array_rst_n, we, a_in, b_in
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: stores A/B operand matrices and drives the diagonal-skewed feed into a 4x4 MAC mesh
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input logic              clk,
    input logic              rst,
    systolic_feeder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t                      state, state_n;
    logic [3:0]                  cnt, cnt_n;
    logic [3:0]                  d;
    logic [DATA_WIDTH-1:0]       a_mem [N][N];
    logic [DATA_WIDTH-1:0]       b_mem [N][N];
    logic [N*DATA_WIDTH-1:0]     a_n, b_n;

    // operand storage: one full row written per load, only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
        end else if (state == IDLE && bus.load_en) begin
            for (int j = 0; j < N; j++)
                if (bus.load_sel)
                    b_mem[bus.load_row][j] <= bus.load_data[DATA_WIDTH*j +: DATA_WIDTH];
                else
                    a_mem[bus.load_row][j] <= bus.load_data[DATA_WIDTH*j +: DATA_WIDTH];
        end
    end

    // sequencer: CLEAR for one cycle, ten FEED steps, one DRAIN, one DONE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE:    if (bus.start) state_n = CLEAR;
            CLEAR: begin
                state_n = FEED;
                cnt_n   = '0;
            end
            FEED:    if (cnt == 4'd9) state_n = DRAIN; else cnt_n = cnt + 4'd1;
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // skewed operands for the upcoming step: row y gets A[y][t-y], column x gets B[t-x][x]
    always_comb begin
        a_n = '0;
        b_n = '0;
        d   = '0;
        for (int i = 0; i < N; i++) begin
            d = cnt_n - 4'(i);
            if (state_n == FEED && cnt_n >= 4'(i) && d < 4'(N)) begin
                a_n[DATA_WIDTH*i +: DATA_WIDTH] = a_mem[i][d[1:0]];
                b_n[DATA_WIDTH*i +: DATA_WIDTH] = b_mem[d[1:0]][i];
            end
        end
    end

    // state and registered outputs, all derived from the next state so outputs align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.array_rst_n <= 1'b0;
            bus.we          <= 1'b0;
            bus.a_in        <= '0;
            bus.b_in        <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bus.busy        <= state_n != IDLE;
            bus.done        <= state_n == DONE;
            bus.array_rst_n <= state_n != CLEAR;
            bus.we          <= state_n == FEED;
            bus.a_in        <= a_n;
            bus.b_in        <= b_n;
        end
    end
endmodule
